// File: rtl/sccb_pkg.sv
// Shared encodings for the SCCB configuration sequencer: table opcodes,
// error codes, ID register addresses and the sequencer state/context types.
package sccb_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ID      = 2'b10;

  localparam logic [7:0] REG_PID = 8'h0A;
  localparam logic [7:0] REG_VER = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FWAIT,
    ST_DECODE,
    ST_NEXT,
    ST_ISSUE,
    ST_WAIT,
    ST_RELEASE,
    ST_DLY,
    ST_RD_PID,
    ST_RD_VER,
    ST_CHECK,
    ST_READY,
    ST_ERROR
  } state_t;

  // Who started the current core transaction; selects where RELEASE returns.
  typedef enum logic [1:0] {
    CTX_TBL,
    CTX_PID,
    CTX_VER,
    CTX_HOST
  } ctx_t;

endpackage

// File: rtl/sccb_ms_timer.sv
// Millisecond count-down timer: load a number of ms, zero_o rises once that
// many 1 ms ticks (CLK_FREQ/1000 cycles each) have elapsed.
module sccb_ms_timer #(
  parameter int CLK_FREQ = 10_000_000
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       load_i,
  input  logic [7:0] ms_i,
  output logic       zero_o
);

  localparam int TICK = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int CW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK - 1);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [7:0]    ms_q, ms_d;

  always_comb begin
    cyc_d = cyc_q;
    ms_d  = ms_q;
    if (load_i) begin
      ms_d  = ms_i;
      cyc_d = '0;
    end else if (ms_q != 8'd0) begin
      if (cyc_q == TICK_LAST) begin
        cyc_d = '0;
        ms_d  = ms_q - 8'd1;
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cyc_q <= '0;
      ms_q  <= 8'd0;
    end else begin
      cyc_q <= cyc_d;
      ms_q  <= ms_d;
    end
  end

  assign zero_o = (ms_q == 8'd0);

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Table-driven camera bring-up over an SCCB master core: init table, ID check,
// then shared access for one host requester.
module sccb_cfg_sequencer
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ    = 10_000_000,
  parameter logic [7:0] ID_WR       = 8'h42,
  parameter logic [7:0] ID_RD       = 8'h43,
  parameter int         TBL_AW      = 6,
  parameter logic [7:0] PID_EXP     = 8'h76,
  parameter logic [7:0] VER_EXP     = 8'h73,
  parameter int         TIMEOUT_CYC = 200_000
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              restart,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [17:0]       tbl_data,
  output logic              core_start,
  output logic              core_rw,
  output logic [7:0]        core_id_addr,
  output logic [7:0]        core_sub_addr,
  output logic [7:0]        core_data_in,
  input  logic [7:0]        core_data_out,
  input  logic              core_done,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [7:0]        host_sub_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              init_done,
  output logic              init_err,
  output logic [1:0]        err_code,
  output logic [7:0]        pid,
  output logic [7:0]        ver,
  output logic [3:0]        dbg_state
);

  // Handshakes: core_start is a level request held (fields stable) until
  // core_done is sampled high; a new request waits for core_done to fall.
  // host_req is a level held by the host until the one-cycle host_ack.

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state_q;
  ctx_t              ctx_q;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic [TW-1:0]     tmo_q;
  logic              core_start_q, core_rw_q;
  logic [7:0]        core_id_q, core_sub_q, core_din_q;
  logic              host_ack_q;
  logic [7:0]        host_rdata_q, pid_q, ver_q;
  logic              init_done_q, init_err_q;
  logic [1:0]        err_code_q;

  logic [1:0] tbl_op;
  logic [7:0] tbl_sub, tbl_dat;
  logic       tmr_load, tmr_zero;

  assign tbl_op  = tbl_data[17:16];
  assign tbl_sub = tbl_data[15:8];
  assign tbl_dat = tbl_data[7:0];

  assign tmr_load = (state_q == ST_DECODE) && (tbl_op == OP_DELAY) && (tbl_dat != 8'd0);

  sccb_ms_timer #(
    .CLK_FREQ(CLK_FREQ)
  ) u_timer (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .load_i (tmr_load),
    .ms_i   (tbl_dat),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q      <= ST_IDLE;
      ctx_q        <= CTX_TBL;
      tbl_addr_q   <= '0;
      tmo_q        <= '0;
      core_start_q <= 1'b0;
      core_rw_q    <= 1'b0;
      core_id_q    <= 8'h00;
      core_sub_q   <= 8'h00;
      core_din_q   <= 8'h00;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      pid_q        <= 8'h00;
      ver_q        <= 8'h00;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      host_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE:  state_q <= ST_FETCH;
        ST_FETCH: state_q <= ST_FWAIT;
        ST_FWAIT: state_q <= ST_DECODE;
        ST_DECODE: begin
          case (tbl_op)
            OP_WRITE: begin
              core_rw_q  <= 1'b0;
              core_id_q  <= ID_WR;
              core_sub_q <= tbl_sub;
              core_din_q <= tbl_dat;
              ctx_q      <= CTX_TBL;
              state_q    <= ST_ISSUE;
            end
            OP_DELAY: state_q <= (tbl_dat == 8'd0) ? ST_NEXT : ST_DLY;
            OP_END:   state_q <= ST_RD_PID;
            default:  state_q <= ST_NEXT;
          endcase
        end
        ST_NEXT: begin
          // The table address saturates at the top entry instead of wrapping.
          if (tbl_addr_q == '1) begin
            state_q <= ST_RD_PID;
          end else begin
            tbl_addr_q <= tbl_addr_q + TBL_AW'(1);
            state_q    <= ST_FETCH;
          end
        end
        ST_ISSUE: begin
          core_start_q <= 1'b1;
          tmo_q        <= '0;
          state_q      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            core_start_q <= 1'b0;
            if (core_rw_q) begin
              case (ctx_q)
                CTX_PID:  pid_q        <= core_data_out;
                CTX_VER:  ver_q        <= core_data_out;
                CTX_HOST: host_rdata_q <= core_data_out;
                default:  ;
              endcase
            end
            state_q <= ST_RELEASE;
          end else if (tmo_q == TMO_LAST) begin
            core_start_q <= 1'b0;
            err_code_q   <= ERR_TIMEOUT;
            init_err_q   <= 1'b1;
            state_q      <= ST_ERROR;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_RELEASE: begin
          if (!core_done) begin
            case (ctx_q)
              CTX_TBL: state_q <= ST_NEXT;
              CTX_PID: state_q <= ST_RD_VER;
              CTX_VER: state_q <= ST_CHECK;
              default: begin
                host_ack_q <= 1'b1;
                state_q    <= ST_READY;
              end
            endcase
          end
        end
        ST_DLY: if (tmr_zero) state_q <= ST_NEXT;
        ST_RD_PID: begin
          core_rw_q  <= 1'b1;
          core_id_q  <= ID_RD;
          core_sub_q <= REG_PID;
          core_din_q <= 8'h00;
          ctx_q      <= CTX_PID;
          state_q    <= ST_ISSUE;
        end
        ST_RD_VER: begin
          core_rw_q  <= 1'b1;
          core_id_q  <= ID_RD;
          core_sub_q <= REG_VER;
          core_din_q <= 8'h00;
          ctx_q      <= CTX_VER;
          state_q    <= ST_ISSUE;
        end
        ST_CHECK: begin
          if (pid_q == PID_EXP && ver_q == VER_EXP) begin
            init_done_q <= 1'b1;
            state_q     <= ST_READY;
          end else begin
            err_code_q <= ERR_ID;
            init_err_q <= 1'b1;
            state_q    <= ST_ERROR;
          end
        end
        ST_READY, ST_ERROR: begin
          // restart beats a simultaneous host request, which stays pending.
          if (restart) begin
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            pid_q       <= 8'h00;
            ver_q       <= 8'h00;
            tbl_addr_q  <= '0;
            state_q     <= ST_FETCH;
          end else if (state_q == ST_READY && host_req && !host_ack_q) begin
            core_rw_q  <= host_rw;
            core_id_q  <= host_rw ? ID_RD : ID_WR;
            core_sub_q <= host_sub_addr;
            core_din_q <= host_wdata;
            ctx_q      <= CTX_HOST;
            state_q    <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tbl_addr      = tbl_addr_q;
  assign core_start    = core_start_q;
  assign core_rw       = core_rw_q;
  assign core_id_addr  = core_id_q;
  assign core_sub_addr = core_sub_q;
  assign core_data_in  = core_din_q;
  assign host_ack      = host_ack_q;
  assign host_rdata    = host_rdata_q;
  assign init_done     = init_done_q;
  assign init_err      = init_err_q;
  assign err_code      = err_code_q;
  assign pid           = pid_q;
  assign ver           = ver_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: table ROM and SCCB core models,
// expected-transaction queue and immediate-assertion checks.
module tb_sccb_cfg_sequencer;
  import sccb_pkg::*;

  localparam int TMO = 2000;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        restart;
  logic [5:0]  tbl_addr;
  logic [17:0] tbl_data;
  logic        core_start, core_rw;
  logic [7:0]  core_id_addr, core_sub_addr, core_data_in;
  logic [7:0]  core_data_out;
  logic        core_done;
  logic        host_req, host_rw;
  logic [7:0]  host_sub_addr, host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        init_done, init_err;
  logic [1:0]  err_code;
  logic [7:0]  pid, ver;
  logic [3:0]  dbg_state;

  sccb_cfg_sequencer #(.TIMEOUT_CYC(TMO)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .restart(restart),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .core_start(core_start), .core_rw(core_rw), .core_id_addr(core_id_addr),
    .core_sub_addr(core_sub_addr), .core_data_in(core_data_in),
    .core_data_out(core_data_out), .core_done(core_done),
    .host_req(host_req), .host_rw(host_rw), .host_sub_addr(host_sub_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .init_done(init_done), .init_err(init_err), .err_code(err_code),
    .pid(pid), .ver(ver), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 PCLK = ~PCLK;
  int cyc = 0;
  always @(posedge PCLK) cyc++;

  // ---------------- table ROM model ----------------
  logic [17:0] rom [64];
  always @(posedge PCLK) tbl_data <= rom[tbl_addr];

  // ---------------- SCCB core model ----------------
  logic [7:0]  regs [256];
  logic [24:0] got_q [$];
  int          got_cyc_q [$];
  int lat = 3, done_hold = 1, hang_at = -1, txn_total = 0;

  initial begin
    core_done = 1'b0;
    core_data_out = 8'h00;
    forever begin
      @(posedge PCLK);
      if (core_start === 1'b1 && core_done === 1'b0) begin
        txn_total++;
        got_q.push_back({core_rw, core_id_addr, core_sub_addr, core_rw ? 8'h00 : core_data_in});
        got_cyc_q.push_back(cyc);
        if (txn_total == hang_at) begin
          while (core_start === 1'b1) @(posedge PCLK);
        end else begin
          repeat (lat - 1) @(posedge PCLK);
          #1;
          if (core_rw === 1'b0) regs[core_sub_addr] = core_data_in;
          core_data_out = core_rw ? regs[core_sub_addr] : 8'h00;
          core_done = 1'b1;
          repeat (done_hold) @(posedge PCLK);
          #1 core_done = 1'b0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int ack_hi = 0, ack_early = 0, wraps = 0;
  logic [5:0] prev_addr = 6'd0;
  always @(negedge PCLK) begin
    if (PRESETN === 1'b1 && host_ack === 1'b1) begin
      ack_hi++;
      if (init_done !== 1'b1) ack_early++;
    end
    if (prev_addr == 6'd63 && tbl_addr == 6'd0) wraps++;
    prev_addr <= tbl_addr;
  end

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q [$];
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] txn(input logic rw, input logic [7:0] id,
                                      input logic [7:0] sub, input logic [7:0] din);
    return {rw, id, sub, din};
  endfunction

  task automatic check_txns(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_txn"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_status(input string tag, input int budget);
    int n = 0;
    while (!(init_done === 1'b1 || init_err === 1'b1) && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check({tag, "_status_reached"}, n < budget, 1);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n = 0;
    while (host_ack !== 1'b1 && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check({tag, "_ack_reached"}, n < budget, 1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge PCLK);
    restart = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) rom[i] = {OP_NOP, 16'h0000};
  endtask

  // ---------------- directed sequence ----------------
  int gap, dur, ack_base;

  initial begin
    PRESETN = 1'b0; restart = 1'b0;
    host_req = 1'b0; host_rw = 1'b0; host_sub_addr = 8'h00; host_wdata = 8'h00;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'h0A] = 8'h76;
    regs[8'h0B] = 8'h73;
    fill_nop();
    rom[0] = {OP_WRITE, 8'h12, 8'h80};
    rom[1] = {OP_DELAY, 8'h00, 8'd2};
    rom[2] = {OP_WRITE, 8'h11, 8'h01};
    rom[3] = {OP_END,   8'h00, 8'h00};

    // Reset values
    repeat (3) @(negedge PCLK);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_core_start", core_start, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_err", init_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_state", dbg_state, ST_IDLE);
    PRESETN = 1'b1;
    @(negedge PCLK);
    check("first_fetch", dbg_state, ST_FETCH);

    // Init table with a host write pending during init
    repeat (4) @(negedge PCLK);
    host_rw = 1'b0; host_sub_addr = 8'h40; host_wdata = 8'hD0; host_req = 1'b1;
    exp_q.push_back(txn(1'b0, 8'h42, 8'h12, 8'h80));
    exp_q.push_back(txn(1'b0, 8'h42, 8'h11, 8'h01));
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0A, 8'h00));
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0B, 8'h00));
    exp_q.push_back(txn(1'b0, 8'h42, 8'h40, 8'hD0));
    wait_status("init1", 30000);
    check("init1_done", init_done, 1);
    check("init1_err", init_err, 0);
    check("init1_err_code", err_code, 0);
    check("init1_pid", pid, 8'h76);
    check("init1_ver", ver, 8'h73);
    wait_ack("hwr", 200);
    host_req = 1'b0;
    repeat (20) @(negedge PCLK);
    check("hwr_no_early_ack", ack_early, 0);
    check("hwr_ack_width", ack_hi, 1);
    gap = (got_cyc_q.size() >= 2) ? got_cyc_q[1] - got_cyc_q[0] : 0;
    check("delay_gap_min", gap >= 20000, 1);
    check("delay_gap_max", gap <= 20100, 1);
    check_txns("init1");

    // Host read with done held high for 5 cycles
    done_hold = 5;
    ack_base = ack_hi;
    host_rw = 1'b1; host_sub_addr = 8'h0A; host_req = 1'b1;
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0A, 8'h00));
    wait_ack("hrd", 200);
    check("hrd_rdata", host_rdata, 8'h76);
    host_req = 1'b0;
    repeat (20) @(negedge PCLK);
    check("hrd_one_ack", ack_hi - ack_base, 1);
    check("hrd_rdata_held", host_rdata, 8'h76);
    check_txns("hrd");
    done_hold = 1;

    // VER mismatch
    regs[8'h0B] = 8'h00;
    fill_nop();
    rom[0] = {OP_END, 16'h0000};
    pulse_restart();
    check("rs1_init_done_clr", init_done, 0);
    check("rs1_state", dbg_state, ST_FETCH);
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0A, 8'h00));
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0B, 8'h00));
    wait_status("idm", 1000);
    check("idm_err", init_err, 1);
    check("idm_err_code", err_code, 2'b10);
    check("idm_done", init_done, 0);
    check("idm_pid", pid, 8'h76);
    check("idm_ver", ver, 8'h00);
    check("idm_state", dbg_state, ST_ERROR);
    check_txns("idm");

    // Core never answers the second write -> timeout
    regs[8'h0B] = 8'h73;
    fill_nop();
    rom[0] = {OP_WRITE, 8'h12, 8'h80};
    rom[1] = {OP_WRITE, 8'h11, 8'h01};
    rom[2] = {OP_END,   8'h00, 8'h00};
    hang_at = txn_total + 2;
    pulse_restart();
    check("rs2_err_clr", init_err, 0);
    check("rs2_code_clr", err_code, 0);
    check("rs2_pid_clr", pid, 8'h00);
    check("rs2_ver_clr", ver, 8'h00);
    exp_q.push_back(txn(1'b0, 8'h42, 8'h12, 8'h80));
    exp_q.push_back(txn(1'b0, 8'h42, 8'h11, 8'h01));
    wait_status("tmo", TMO + 500);
    dur = (got_cyc_q.size() >= 2) ? cyc - got_cyc_q[1] : 0;
    check("tmo_err", init_err, 1);
    check("tmo_err_code", err_code, 2'b01);
    check("tmo_core_start", core_start, 0);
    check("tmo_dur_min", dur >= TMO - 5, 1);
    check("tmo_dur_max", dur <= TMO + 10, 1);
    check_txns("tmo");
    hang_at = -1;
    pulse_restart();
    check("rs3_tbl_addr", tbl_addr, 0);
    exp_q.push_back(txn(1'b0, 8'h42, 8'h12, 8'h80));
    exp_q.push_back(txn(1'b0, 8'h42, 8'h11, 8'h01));
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0A, 8'h00));
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0B, 8'h00));
    wait_status("rerun", 1000);
    check("rerun_done", init_done, 1);
    check_txns("rerun");

    // Table without END: address saturates at 63, then ID reads
    fill_nop();
    pulse_restart();
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0A, 8'h00));
    exp_q.push_back(txn(1'b1, 8'h43, 8'h0B, 8'h00));
    wait_status("noend", 2000);
    check("noend_done", init_done, 1);
    check("noend_addr", tbl_addr, 63);
    check("noend_no_wrap", wraps, 0);
    check("noend_state", dbg_state, ST_READY);
    check_txns("noend");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
